// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: instruction-word bit map,
// the idle instruction, address/counter widths and the FSM state set.
package core_ctrl_pkg;

  localparam int INST_W = 36;
  localparam int XA_W   = 10;  // activation/weight SRAM address width
  localparam int PA_W   = 11;  // psum SRAM address width
  localparam int CNT_W  = 11;  // holds 0..1024 activation vectors

  // Instruction word bit positions
  localparam int B_ACC      = 35;
  localparam int B_CEN_P    = 34;
  localparam int B_WEN_P    = 33;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs deselected (active-low CEN/WEN high), everything else quiet
  localparam logic [INST_W-1:0] INST_IDLE = 36'h6_000C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_KER,
    S_W_GAP,
    S_X_RD,
    S_EXEC,
    S_DRAIN,
    S_SFP_RD,
    S_SFP_WAIT,
    S_SFP_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_ctrl.sv
// Core run sequencer: loads a weight kernel, streams activations, drains
// the OFIFO into psum memory and optionally runs the SFP write-back pass.
// Every output is a flop fed from the decode of the current state, so the
// instruction stream trails the state register by one cycle.
//
// Handshake: ofifo_valid is sampled at the clock edge while draining; when
// it is high and reads remain, ofifo_rd is raised for the following cycle,
// and the matching pmem write is issued in the cycle after that.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int SFP_LAT = 2,
  parameter int KGAP    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  w_base,
  input  logic [9:0]  x_base,
  input  logic [10:0] p_base,
  input  logic [10:0] num_x,
  input  logic        sfp_en,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        xw_mode,
  output logic        pmem_mode,
  output logic        sfp_reset,
  output logic        busy,
  output logic        done
);

  if (ROW < 1 || COL < 1 || SFP_LAT < 1 || KGAP < 1) begin : g_param_check
    $error("core_ctrl: ROW, COL, SFP_LAT and KGAP must all be >= 1");
  end

  localparam logic [CNT_W-1:0] COL_C     = CNT_W'(COL);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] KGAP_LAST = CNT_W'(KGAP - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((SFP_LAT >= 2) ? SFP_LAT - 2 : 0);

  // state_q is the FSM state visible to checkers bound into this block
  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;   // phase counter; reads issued while draining
  logic [PA_W-1:0]   j, j_n;       // drain / write-back index
  logic              pend, pend_n; // an OFIFO read awaits its pmem write

  logic [XA_W-1:0]   w_base_r, x_base_r;
  logic [PA_W-1:0]   p_base_r;
  logic [CNT_W-1:0]  num_x_r;
  logic              sfp_en_r;

  logic [INST_W-1:0] inst_d;
  logic              xw_d, pm_d, sfr_d, busy_d, done_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt       <= '0;
      j         <= '0;
      pend      <= 1'b0;
      inst      <= INST_IDLE;
      xw_mode   <= 1'b0;
      pmem_mode <= 1'b0;
      sfp_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt       <= cnt_n;
      j         <= j_n;
      pend      <= pend_n;
      inst      <= inst_d;
      xw_mode   <= xw_d;
      pmem_mode <= pm_d;
      sfp_reset <= sfr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Run parameters are captured once, when a run is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_r <= '0;
      x_base_r <= '0;
      p_base_r <= '0;
      num_x_r  <= '0;
      sfp_en_r <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      w_base_r <= w_base;
      x_base_r <= x_base;
      p_base_r <= p_base;
      num_x_r  <= num_x;
      sfp_en_r <= sfp_en;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt;
    j_n     = j;
    pend_n  = 1'b0;
    inst_d  = INST_IDLE;
    xw_d    = 1'b0;
    pm_d    = 1'b0;
    sfr_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          state_n = S_W_RD;
          cnt_n   = '0;
          j_n     = '0;
        end
      end
      S_W_RD: begin
        xw_d = 1'b1;
        if (cnt < COL_C) begin
          inst_d[B_CEN_X]               = 1'b0;
          inst_d[B_AX_LSB +: XA_W]      = w_base_r + cnt[XA_W-1:0];
        end
        if (cnt != '0) inst_d[B_L0_WR] = 1'b1;  // SRAM data arrives a cycle late
        if (cnt == COL_C) begin
          state_n = S_W_KER;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_W_KER: begin
        xw_d            = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
        if (cnt == COL_LAST) begin
          state_n = S_W_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_W_GAP: begin
        xw_d = 1'b1;
        if (cnt == KGAP_LAST) begin
          state_n = (num_x_r == '0) ? S_DONE : S_X_RD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_X_RD: begin
        if (cnt < num_x_r) begin
          inst_d[B_CEN_X]          = 1'b0;
          inst_d[B_AX_LSB +: XA_W] = x_base_r + cnt[XA_W-1:0];
        end
        if (cnt != '0) inst_d[B_L0_WR] = 1'b1;
        if (cnt == num_x_r) begin
          state_n = S_EXEC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
        if (cnt == num_x_r - 1'b1) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
          j_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (pend) begin
          inst_d[B_CEN_P]          = 1'b0;
          inst_d[B_WEN_P]          = 1'b0;
          inst_d[B_AP_LSB +: PA_W] = p_base_r + j;
          j_n                      = j + 1'b1;
        end
        if (ofifo_valid && cnt < num_x_r) begin
          inst_d[B_OFIFO_RD] = 1'b1;
          pend_n             = 1'b1;
          cnt_n              = cnt + 1'b1;
        end
        if (pend && j == num_x_r - 1'b1) begin
          state_n = sfp_en_r ? S_SFP_RD : S_DONE;
          cnt_n   = '0;
          j_n     = '0;
        end
      end
      S_SFP_RD: begin
        pm_d                     = 1'b1;
        sfr_d                    = (j == '0);
        inst_d[B_CEN_P]          = 1'b0;
        inst_d[B_ACC]            = 1'b1;
        inst_d[B_AP_LSB +: PA_W] = p_base_r + j;
        state_n                  = (SFP_LAT == 1) ? S_SFP_WR : S_SFP_WAIT;
        cnt_n                    = '0;
      end
      S_SFP_WAIT: begin
        pm_d = 1'b1;
        if (cnt == WAIT_LAST) begin
          state_n = S_SFP_WR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SFP_WR: begin
        pm_d                     = 1'b1;
        inst_d[B_CEN_P]          = 1'b0;
        inst_d[B_WEN_P]          = 1'b0;
        inst_d[B_AP_LSB +: PA_W] = p_base_r + j;
        if (j == num_x_r - 1'b1) begin
          state_n = S_DONE;
          j_n     = '0;
        end else begin
          state_n = S_SFP_RD;
          j_n     = j + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
